// File: rtl/ahb_slave_fifo_front.sv
// ahb_slave_fifo_front: AHB slave front end that queues bridge transfers into an ordered request FIFO
module ahb_slave_fifo_front #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       HSELAPB,
  input  logic [ADDR_W-1:0]          HADDR,
  input  logic [1:0]                 HTRANS,
  input  logic                       HWRITE,
  input  logic [2:0]                 HSIZE,
  input  logic [2:0]                 HBURST,
  input  logic [DATA_W-1:0]          HWDATA,
  input  logic                       HREADYin,
  output logic                       HREADYout,
  output logic [1:0]                 HRESP,
  output logic [DATA_W-1:0]          HRDATA,
  output logic                       req_valid,
  input  logic                       req_ready,
  output logic [ADDR_W-1:0]          req_addr,
  output logic                       req_write,
  output logic [2:0]                 req_size,
  output logic [DATA_W-1:0]          req_wdata,
  input  logic                       rsp_valid,
  input  logic [DATA_W-1:0]          rsp_rdata,
  input  logic                       rsp_err,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int EW = ADDR_W + 4 + DATA_W;
  localparam logic [2:0] MAXS = (DATA_W == 64) ? 3'd3 : 3'd2;
  typedef enum logic [2:0] {IDLE, WDATA, WSTALL, RPUSH, RWAIT, RDONE, ERR1, ERR2} state_t;
  state_t state, nstate, acc_state;
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [ADDR_W-1:0] hold_addr;
  logic [2:0] hold_size;
  logic [DATA_W-1:0] wbuf, push_data;
  logic [LW-1:0] level_next;
  logic space, open, accept, illegal, push, pop, unused_hburst;
  assign unused_hburst = ^HBURST;
  assign space = fifo_level < LW'(DEPTH);
  assign open = (state inside {IDLE, RDONE, ERR2}) | (state == WDATA & space);
  assign accept = open & HSELAPB & HREADYin & HTRANS[1];
  assign illegal = (HSIZE > MAXS) | ((HADDR[2:0] & ~(3'h7 << HSIZE)) != 3'h0);
  assign acc_state = !accept ? IDLE : illegal ? ERR1 : HWRITE ? WDATA : RPUSH;
  assign push = space & (state inside {WDATA, WSTALL, RPUSH});
  assign pop = req_valid & req_ready;
  assign push_data = state == WDATA ? HWDATA : state == WSTALL ? wbuf : '0;
  assign level_next = fifo_level + LW'(push) - LW'(pop);
  assign req_valid = fifo_level != '0;
  assign {req_addr, req_write, req_size, req_wdata} = req_valid ? mem[rptr] : '0;
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE, RDONE, ERR2: nstate = acc_state;
      WDATA:  nstate = space ? acc_state : WSTALL;
      WSTALL: nstate = space ? IDLE : WSTALL;
      RPUSH:  nstate = space ? RWAIT : RPUSH;
      RWAIT:  nstate = !rsp_valid ? RWAIT : rsp_err ? ERR1 : RDONE;
      ERR1:   nstate = ERR2;
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge clock)
    if (push) mem[wptr] <= {hold_addr, state != RPUSH, hold_size, push_data};
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      HREADYout <= 1'b1;
      HRESP <= 2'b00;
      HRDATA <= '0;
      hold_addr <= '0;
      hold_size <= '0;
      wbuf <= '0;
      wptr <= '0;
      rptr <= '0;
      fifo_level <= '0;
    end else begin
      state <= nstate;
      HREADYout <= (nstate inside {IDLE, RDONE, ERR2}) | (nstate == WDATA & level_next < LW'(DEPTH));
      HRESP <= {1'b0, nstate inside {ERR1, ERR2}};
      if (accept) begin
        hold_addr <= HADDR;
        hold_size <= HSIZE;
      end
      if (state == WDATA & !space) wbuf <= HWDATA;
      if (state == RWAIT & rsp_valid & !rsp_err) HRDATA <= rsp_rdata;
      if (push) wptr <= wptr + PW'(1);
      if (pop) rptr <= rptr + PW'(1);
      fifo_level <= level_next;
    end
  end
endmodule

// File: tb/tb_ahb_slave_fifo_front.sv
// tb_ahb_slave_fifo_front: scoreboard bench for the AHB slave FIFO front end
module tb_ahb_slave_fifo_front;
  logic clock = 0, reset = 1;
  logic HSELAPB = 0, HWRITE = 0, HREADYin, HREADYout, req_valid, req_ready = 0, req_write;
  logic rsp_valid = 0, rsp_err = 0;
  logic [31:0] HADDR = 0, HWDATA = 0, HRDATA, req_addr, req_wdata, rsp_rdata = 0;
  logic [1:0] HTRANS = 0, HRESP;
  logic [2:0] HSIZE = 0, HBURST = 0, req_size, fifo_level;
  typedef struct packed {logic [31:0] a; logic w; logic [2:0] s; logic [31:0] d;} req_t;
  req_t exp_q[$];
  req_t got;
  int passed = 0, total = 0;
  assign HREADYin = HREADYout;
  always #5 clock = ~clock;
  ahb_slave_fifo_front dut (
    .clock(clock), .reset(reset), .HSELAPB(HSELAPB), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADYin(HREADYin),
    .HREADYout(HREADYout), .HRESP(HRESP), .HRDATA(HRDATA), .req_valid(req_valid),
    .req_ready(req_ready), .req_addr(req_addr), .req_write(req_write), .req_size(req_size),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .fifo_level(fifo_level)
  );
  always @(negedge clock)
    if (!reset && req_valid && req_ready) begin
      total++;
      if (exp_q.size() == 0) $display("FAIL sb_unexpected got %h/%b/%0d/%h", req_addr, req_write, req_size, req_wdata);
      else begin
        got = exp_q.pop_front();
        if ({req_addr, req_write, req_size, req_wdata} !== got)
          $display("FAIL sb_head got %h/%b/%0d/%h want %h/%b/%0d/%h", req_addr, req_write, req_size, req_wdata, got.a, got.w, got.s, got.d);
        else passed++;
      end
    end
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic drive(input logic sel, input logic [1:0] tr, input logic w, input logic [31:0] a, input logic [2:0] s);
    HSELAPB = sel;
    HTRANS = tr;
    HWRITE = w;
    HADDR = a;
    HSIZE = s;
  endtask
  task automatic test_reset();
    reset = 1;
    step();
    step();
    reset = 0;
    total += 6;
    if (HREADYout !== 1'b1) $display("FAIL rst_hready got %b want 1", HREADYout); else passed++;
    if (HRESP !== 2'b00) $display("FAIL rst_hresp got %b want 00", HRESP); else passed++;
    if (HRDATA !== 32'h0) $display("FAIL rst_hrdata got %h want 0", HRDATA); else passed++;
    if (fifo_level !== 3'd0) $display("FAIL rst_level got %0d want 0", fifo_level); else passed++;
    if (req_valid !== 1'b0) $display("FAIL rst_req_valid got %b want 0", req_valid); else passed++;
    if (req_addr !== 32'h0) $display("FAIL rst_req_addr got %h want 0", req_addr); else passed++;
  endtask
  task automatic test_back_to_back();
    req_ready = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 2'b10, 1, 32'(i * 4), 3'd2);
      if (i > 0) HWDATA = 32'hD000_0000 + 32'(i - 1);
      exp_q.push_back('{32'(i * 4), 1'b1, 3'd2, 32'hD000_0000 + 32'(i)});
      total++;
      if (HREADYout !== 1'b1) $display("FAIL b2b_ready%0d got %b want 1", i, HREADYout); else passed++;
      step();
    end
    drive(0, 2'b00, 0, 0, 0);
    HWDATA = 32'hD000_0004;
    total += 2;
    if (fifo_level !== 3'd4) $display("FAIL b2b_full_level got %0d want 4", fifo_level); else passed++;
    if (HREADYout !== 1'b0) $display("FAIL b2b_full_wait got %b want 0", HREADYout); else passed++;
    step();
    req_ready = 1;
    total++;
    if (HREADYout !== 1'b0) $display("FAIL b2b_stall_wait got %b want 0", HREADYout); else passed++;
    step();
    req_ready = 0;
    total += 2;
    if (HREADYout !== 1'b0) $display("FAIL b2b_push_wait got %b want 0", HREADYout); else passed++;
    if (fifo_level !== 3'd3) $display("FAIL b2b_pop_level got %0d want 3", fifo_level); else passed++;
    step();
    total += 2;
    if (HREADYout !== 1'b1) $display("FAIL b2b_done_ready got %b want 1", HREADYout); else passed++;
    if (fifo_level !== 3'd4) $display("FAIL b2b_refill_level got %0d want 4", fifo_level); else passed++;
    req_ready = 1;
    repeat (4) step();
    req_ready = 0;
    total += 2;
    if (fifo_level !== 3'd0) $display("FAIL b2b_drain_level got %0d want 0", fifo_level); else passed++;
    if (req_valid !== 1'b0) $display("FAIL b2b_drain_valid got %b want 0", req_valid); else passed++;
  endtask
  task automatic test_reset_stall();
    req_ready = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 2'b10, 1, 32'h40 + 32'(i * 4), 3'd2);
      HWDATA = 32'hC000_0000 + 32'(i);
      step();
    end
    drive(0, 2'b00, 0, 0, 0);
    step();
    total++;
    if (HREADYout !== 1'b0) $display("FAIL rs_stalled got %b want 0", HREADYout); else passed++;
    reset = 1;
    step();
    step();
    reset = 0;
    step();
    total += 4;
    if (HREADYout !== 1'b1) $display("FAIL rs_hready got %b want 1", HREADYout); else passed++;
    if (HRESP !== 2'b00) $display("FAIL rs_hresp got %b want 00", HRESP); else passed++;
    if (fifo_level !== 3'd0) $display("FAIL rs_level got %0d want 0", fifo_level); else passed++;
    if (req_valid !== 1'b0) $display("FAIL rs_req_valid got %b want 0", req_valid); else passed++;
  endtask
  task automatic test_write_read();
    req_ready = 1;
    drive(1, 2'b10, 1, 32'h20, 3'd2);
    exp_q.push_back('{32'h20, 1'b1, 3'd2, 32'hA5A5_A5A5});
    step();
    HWDATA = 32'hA5A5_A5A5;
    drive(1, 2'b10, 0, 32'h20, 3'd2);
    exp_q.push_back('{32'h20, 1'b0, 3'd2, 32'h0});
    total++;
    if (HREADYout !== 1'b1) $display("FAIL wr_wdata_ready got %b want 1", HREADYout); else passed++;
    step();
    drive(0, 2'b00, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        rsp_valid = 1;
        rsp_rdata = 32'hA5A5_A5A5;
      end
      total++;
      if (HREADYout !== 1'b0) $display("FAIL wr_read_wait%0d got %b want 0", i, HREADYout); else passed++;
      step();
    end
    rsp_valid = 0;
    total += 3;
    if (HREADYout !== 1'b1) $display("FAIL wr_rdone_ready got %b want 1", HREADYout); else passed++;
    if (HRESP !== 2'b00) $display("FAIL wr_rdone_resp got %b want 00", HRESP); else passed++;
    if (HRDATA !== 32'hA5A5_A5A5) $display("FAIL wr_hrdata got %h want a5a5a5a5", HRDATA); else passed++;
    step();
    rsp_valid = 1;
    rsp_rdata = 32'hDEAD_BEEF;
    step();
    rsp_valid = 0;
    req_ready = 0;
    total += 2;
    if (HRDATA !== 32'hA5A5_A5A5) $display("FAIL wr_stray_rsp got %h want a5a5a5a5", HRDATA); else passed++;
    if (HREADYout !== 1'b1) $display("FAIL wr_stray_ready got %b want 1", HREADYout); else passed++;
  endtask
  task automatic test_illegal();
    logic [31:0] addrs [2] = '{32'h02, 32'h08};
    logic [2:0] sizes [2] = '{3'd2, 3'd3};
    req_ready = 0;
    for (int i = 0; i < 2; i++) begin
      drive(1, 2'b10, i == 0, addrs[i], sizes[i]);
      step();
      drive(0, 2'b00, 0, 0, 0);
      total += 2;
      if (HREADYout !== 1'b0) $display("FAIL ill%0d_err1_ready got %b want 0", i, HREADYout); else passed++;
      if (HRESP !== 2'b01) $display("FAIL ill%0d_err1_resp got %b want 01", i, HRESP); else passed++;
      step();
      total += 2;
      if (HREADYout !== 1'b1) $display("FAIL ill%0d_err2_ready got %b want 1", i, HREADYout); else passed++;
      if (HRESP !== 2'b01) $display("FAIL ill%0d_err2_resp got %b want 01", i, HRESP); else passed++;
      step();
      total += 3;
      if (HREADYout !== 1'b1) $display("FAIL ill%0d_after_ready got %b want 1", i, HREADYout); else passed++;
      if (HRESP !== 2'b00) $display("FAIL ill%0d_after_resp got %b want 00", i, HRESP); else passed++;
      if (fifo_level !== 3'd0) $display("FAIL ill%0d_level got %0d want 0", i, fifo_level); else passed++;
    end
  endtask
  task automatic test_read_err();
    req_ready = 1;
    drive(1, 2'b10, 0, 32'h30, 3'd2);
    exp_q.push_back('{32'h30, 1'b0, 3'd2, 32'h0});
    step();
    drive(0, 2'b00, 0, 0, 0);
    total++;
    if (HREADYout !== 1'b0) $display("FAIL re_rpush_ready got %b want 0", HREADYout); else passed++;
    step();
    rsp_valid = 1;
    rsp_err = 1;
    rsp_rdata = 32'hBAD0_BAD0;
    step();
    rsp_valid = 0;
    rsp_err = 0;
    total += 2;
    if (HREADYout !== 1'b0) $display("FAIL re_err1_ready got %b want 0", HREADYout); else passed++;
    if (HRESP !== 2'b01) $display("FAIL re_err1_resp got %b want 01", HRESP); else passed++;
    step();
    total += 2;
    if (HREADYout !== 1'b1) $display("FAIL re_err2_ready got %b want 1", HREADYout); else passed++;
    if (HRESP !== 2'b01) $display("FAIL re_err2_resp got %b want 01", HRESP); else passed++;
    drive(1, 2'b10, 0, 32'h34, 3'd2);
    exp_q.push_back('{32'h34, 1'b0, 3'd2, 32'h0});
    step();
    drive(0, 2'b00, 0, 0, 0);
    total += 2;
    if (HREADYout !== 1'b0) $display("FAIL re_next_wait got %b want 0", HREADYout); else passed++;
    if (HRESP !== 2'b00) $display("FAIL re_next_resp got %b want 00", HRESP); else passed++;
    step();
    rsp_valid = 1;
    rsp_rdata = 32'h1234_5678;
    step();
    rsp_valid = 0;
    total += 3;
    if (HREADYout !== 1'b1) $display("FAIL re_rdone_ready got %b want 1", HREADYout); else passed++;
    if (HRESP !== 2'b00) $display("FAIL re_rdone_resp got %b want 00", HRESP); else passed++;
    if (HRDATA !== 32'h1234_5678) $display("FAIL re_hrdata got %h want 12345678", HRDATA); else passed++;
    step();
    req_ready = 0;
  endtask
  task automatic test_ignored();
    logic sels [3] = '{1'b1, 1'b1, 1'b0};
    logic [1:0] trs [3] = '{2'b00, 2'b01, 2'b10};
    req_ready = 0;
    for (int i = 0; i < 3; i++) begin
      drive(sels[i], trs[i], 0, 32'h50, 3'd2);
      step();
      total += 2;
      if (HREADYout !== 1'b1) $display("FAIL ign%0d_ready got %b want 1", i, HREADYout); else passed++;
      if (HRESP !== 2'b00) $display("FAIL ign%0d_resp got %b want 00", i, HRESP); else passed++;
    end
    drive(0, 2'b00, 0, 0, 0);
    step();
    total += 2;
    if (fifo_level !== 3'd0) $display("FAIL ign_level got %0d want 0", fifo_level); else passed++;
    if (req_valid !== 1'b0) $display("FAIL ign_req_valid got %b want 0", req_valid); else passed++;
  endtask
  initial begin
    test_reset();
    test_back_to_back();
    test_reset_stall();
    test_write_read();
    test_illegal();
    test_read_err();
    test_ignored();
    total++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover got %0d want 0", exp_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
